// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction at a time over req/ready/rvalid and holds it for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds fetch_fault and a HALT state on misaligned next PC.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            retire,
  input  logic            Branch,
  input  logic            br_taken,
  input  logic            Con_Jal,
  input  logic            Con_Jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t          state;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;

  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign pc_plus4  = pc + XLEN'(4);

  always_comb begin
    target = pc_plus4;
    if (Con_Jalr)
      target = alu_result & ~XLEN'(1);
    else if (Con_Jal || (Branch && br_taken))
      target = pc + imm;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc = target;
`else
  // Without the trap, low bits are silently dropped so fetches stay word aligned.
  assign next_pc = target & ~XLEN'(3);
`endif

  // imem_req is registered: it stays low through reset and rises on the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            imem_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= S_HALT;
            end else begin
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
`else
            imem_req <= 1'b1;
            state    <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: state <= S_HALT;
`endif
        default: begin
          imem_req <= 1'b0;
          state    <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table of control-flow cases, handshake/reset corner sequences, random fetch/retire.
module tb_instr_fetch_unit;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        retire = 1'b0;
  logic        Branch = 1'b0;
  logic        br_taken = 1'b0;
  logic        Con_Jal = 1'b0;
  logic        Con_Jalr = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .retire(retire), .Branch(Branch), .br_taken(br_taken),
    .Con_Jal(Con_Jal), .Con_Jalr(Con_Jalr), .imm(imm), .alu_result(alu_result),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc;
  logic        retire_noise = 1'b0;

  typedef struct {
    logic        b, t, j, jr;
    logic [31:0] im, al, exp_pc;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Next-PC rules computed with wide integer arithmetic and explicit modulo.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic b, input logic t,
                                           input logic j, input logic jr,
                                           input logic [31:0] im, input logic [31:0] al);
    logic [63:0] tgt;
    if (jr)                tgt = {32'h0, al} - ({32'h0, al} % 2);
    else if (j || (b && t)) tgt = ({32'h0, cur} + {32'h0, im}) % 64'h1_0000_0000;
    else                   tgt = ({32'h0, cur} + 64'd4) % 64'h1_0000_0000;
`ifndef FETCH_MISALIGN_TRAP_EN
    tgt = tgt - (tgt % 4);
`endif
    return tgt[31:0];
  endfunction

  task automatic fetch(input logic [31:0] word, input int rdy_dly, input int rv_dly,
                       input bit stale_rv, input logic [31:0] exp_pc);
    int n = 0;
    retire = retire_noise;
    while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
    check("req_start", 32'(imem_req), 32'd1);
    check("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready = 1'b0;
      if (stale_rv && i == 0) begin imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, exp_pc);
      check("valid_in_req", 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b1;
    if (stale_rv) begin imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD; end
    @(posedge clk); #1;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    check("req_drop", 32'(imem_req), 32'd0);
    check("valid_at_accept", 32'(instr_valid), 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      @(posedge clk); #1;
      check("valid_in_wait", 32'(instr_valid), 32'd0);
      check("req_in_wait", 32'(imem_req), 32'd0);
    end
    imem_rvalid = 1'b1; imem_rdata = word;
    @(posedge clk); #1;
    imem_rvalid = 1'b0; retire = 1'b0;
    check("valid", 32'(instr_valid), 32'd1);
    check("instr", instr, word);
    check("opcode", 32'(opcode), 32'(word[6:0]));
    check("pc", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
  endtask

  task automatic do_retire(input logic b, input logic t, input logic j, input logic jr,
                           input logic [31:0] im, input logic [31:0] al, input logic [31:0] exp_pc);
    Branch = b; br_taken = t; Con_Jal = j; Con_Jalr = jr; imm = im; alu_result = al; retire = 1'b1;
    @(posedge clk); #1;
    retire = 1'b0; Branch = 1'b0; br_taken = 1'b0; Con_Jal = 1'b0; Con_Jalr = 1'b0;
    check("next_pc", pc, exp_pc);
    check("next_addr", imem_addr, exp_pc);
    check("valid_after_retire", 32'(instr_valid), 32'd0);
    check("req_after_retire", 32'(imem_req), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, RPC);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_opcode"}, 32'(opcode), 32'h13);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] w, im, al, exp;
    logic        b, t, j, jr;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8,         32'h0,         32'h0000_0010};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8,         32'h0,         32'h0000_0010};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0014};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hC,         32'h0,         32'h0000_0020};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100,       32'h0,         32'h0000_0120};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h100,       32'h40,        32'h0000_0040};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h80,        32'h0,         32'h0000_0044};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000};

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_req", 32'(imem_req), 32'd1);
    model_pc = RPC;

    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      fetch((i == 0) ? 32'h0050_0093 : w, 0, 0, 1'b0, model_pc);
      do_retire(tbl[i].b, tbl[i].t, tbl[i].j, tbl[i].jr, tbl[i].im, tbl[i].al, tbl[i].exp_pc);
      model_pc = tbl[i].exp_pc;
    end

    // Slow memory, stale rvalid in REQ, rvalid alongside ready, and retire held during the fetch.
    retire_noise = 1'b1;
    fetch(32'h1234_5677, 5, 3, 1'b1, model_pc);
    retire_noise = 1'b0;
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, model_pc + 32'd4);
    model_pc = model_pc + 32'd4;

    for (int i = 0; i < 30; i++) begin
      w = $urandom; b = 1'($urandom); t = 1'($urandom); j = 1'($urandom); jr = 1'($urandom);
      im = $urandom; al = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      im = im & ~32'd3;
      al = al & ~32'd2;
`endif
      exp = ref_next(model_pc, b, t, j, jr, im, al);
      fetch(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), model_pc);
      do_retire(b, t, j, jr, im, al, exp);
      model_pc = exp;
    end

    fetch(32'h0000_0067, 0, 1, 1'b0, model_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    Con_Jalr = 1'b1; alu_result = 32'h0000_0203; retire = 1'b1;
    @(posedge clk); #1;
    Con_Jalr = 1'b0; retire = 1'b0;
    check("trap_fault", 32'(fetch_fault), 32'd1);
    check("trap_pc", pc, 32'h0000_0202);
    check("trap_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      @(posedge clk); #1;
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_fault", 32'(fetch_fault), 32'd1);
    end
    imem_ready = 1'b0;
`else
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0203, 32'h0000_0200);
`endif

    // Reset while waiting for a response; the late response must be ignored.
    reset = 1'b1; #1; reset = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check("pre_wait_req", 32'(imem_req), 32'd0);
    reset = 1'b1; #1;
    check_reset_state("rst_wait");
    @(posedge clk); #1;
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    check("stale_valid", 32'(instr_valid), 32'd0);
    check("stale_instr", instr, NOP);
    check("stale_pc", pc, RPC);
    check("stale_req", 32'(imem_req), 32'd1);

    fetch(32'h00A0_0113, 0, 0, 1'b0, RPC);
    reset = 1'b1; #1;
    check_reset_state("rst_hold");
    @(posedge clk); #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
